ppm_frame_decoder: RTL and testbench

//  Upstream stage of pwm_analyzer in the RC receiver demodulator. Takes the receiver's PPM sum signal,

---
 rtl/ppm_decoder_pkg.sv | 20 ++
 rtl/ppm_input_sync.sv | 54 +++++
 rtl/ppm_frame_decoder.sv | 123 ++++++++++++
 tb/tb_ppm_frame_decoder.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ppm_decoder_pkg.sv
// Shared types and default timing constants for the PPM frame decoder.
// All timing values are in system clock cycles.
package ppm_decoder_pkg;

   localparam int CHANNEL_INDEX_WIDTH     = 3;

   localparam int DEFAULT_NUM_CHANNELS    = 8;
   localparam int DEFAULT_COUNTER_WIDTH   = 16;
   localparam int DEFAULT_MIN_PULSE_VALUE = 800;
   localparam int DEFAULT_MAX_PULSE_VALUE = 2200;
   localparam int DEFAULT_SYNC_GAP_VALUE  = 3000;
   localparam int DEFAULT_TIMEOUT_VALUE   = 50000;

   typedef enum logic [1:0] {
      WAIT_SYNC = 2'd0,
      GAP       = 2'd1,
      CHAN      = 2'd2
   } ppm_state_t;

endpackage

// File: rtl/ppm_input_sync.sv
// PPM input conditioning: 2-FF synchronizer, optional 3-sample majority filter
// (enabled by defining PPM_GLITCH_FILTER_EN), and a registered rising-edge strobe.
module ppm_input_sync (
   input  logic clock_i,
   input  logic reset_i,
   input  logic enable_i,
   input  logic ppm_i,
   output logic edge_o
);

   logic sync_meta;
   logic sync_q;
   logic filtered;
   logic filtered_prev;

   always_ff @(posedge clock_i) begin
      if (reset_i || !enable_i) begin
         sync_meta <= 1'b0;
         sync_q    <= 1'b0;
      end else begin
         sync_meta <= ppm_i;
         sync_q    <= sync_meta;
      end
   end

`ifdef PPM_GLITCH_FILTER_EN
   logic [1:0] history_q;

   // Any single-cycle spike occupies only one of the three samples, so the vote never follows it.
   always_ff @(posedge clock_i) begin
      if (reset_i || !enable_i) begin
         history_q <= '0;
         filtered  <= 1'b0;
      end else begin
         history_q <= {history_q[0], sync_q};
         filtered  <= (sync_q & history_q[0]) | (sync_q & history_q[1]) |
                      (history_q[0] & history_q[1]);
      end
   end
`else
   assign filtered = sync_q;
`endif

   always_ff @(posedge clock_i) begin
      if (reset_i || !enable_i) begin
         filtered_prev <= 1'b0;
         edge_o        <= 1'b0;
      end else begin
         filtered_prev <= filtered;
         edge_o        <= filtered & ~filtered_prev;
      end
   end

endmodule

// File: rtl/ppm_frame_decoder.sv
// PPM sum-signal frame decoder: locks onto the sync gap, measures each channel slot and
// regenerates one selected channel as a PWM pulse. PPM_GLITCH_FILTER_EN enables the input filter.
module ppm_frame_decoder
   import ppm_decoder_pkg::*;
#(
   parameter int NUM_CHANNELS    = DEFAULT_NUM_CHANNELS,
   parameter int COUNTER_WIDTH   = DEFAULT_COUNTER_WIDTH,
   parameter int MIN_PULSE_VALUE = DEFAULT_MIN_PULSE_VALUE,
   parameter int MAX_PULSE_VALUE = DEFAULT_MAX_PULSE_VALUE,
   parameter int SYNC_GAP_VALUE  = DEFAULT_SYNC_GAP_VALUE,
   parameter int TIMEOUT_VALUE   = DEFAULT_TIMEOUT_VALUE
) (
   input  logic                           clock_i,
   input  logic                           reset_i,
   input  logic                           enable_i,
   input  logic                           ppm_i,
   input  logic [CHANNEL_INDEX_WIDTH-1:0] channel_select_i,
   output logic [CHANNEL_INDEX_WIDTH-1:0] channel_index_o,
   output logic [COUNTER_WIDTH-1:0]       channel_width_o,
   output logic                           channel_valid_o,
   output logic                           frame_done_o,
   output logic                           frame_error_o,
   output logic                           signal_lost_o,
   output logic                           servo_pulse_o
);

   localparam logic [COUNTER_WIDTH-1:0] MIN_C     = COUNTER_WIDTH'(MIN_PULSE_VALUE);
   localparam logic [COUNTER_WIDTH-1:0] MAX_C     = COUNTER_WIDTH'(MAX_PULSE_VALUE);
   localparam logic [COUNTER_WIDTH-1:0] SYNC_C    = COUNTER_WIDTH'(SYNC_GAP_VALUE);
   localparam logic [COUNTER_WIDTH-1:0] TIMEOUT_C = COUNTER_WIDTH'(TIMEOUT_VALUE);
   localparam logic [CHANNEL_INDEX_WIDTH-1:0] LAST_INDEX = CHANNEL_INDEX_WIDTH'(NUM_CHANNELS - 1);

   logic                           edge_strobe;
   logic [COUNTER_WIDTH-1:0]       counter_q;
   ppm_state_t                     state_q;
   logic [CHANNEL_INDEX_WIDTH-1:0] index_q;
   logic [CHANNEL_INDEX_WIDTH-1:0] select_q;
   logic                           gap_hit;
   logic                           timeout_hit;
   logic                           interval_ok;
   logic                           start_frame;

   ppm_input_sync u_input_sync (
      .clock_i  (clock_i),
      .reset_i  (reset_i),
      .enable_i (enable_i),
      .ppm_i    (ppm_i),
      .edge_o   (edge_strobe)
   );

   // Restarting at 1 makes the count in an edge cycle equal the edge-to-edge spacing.
   always_ff @(posedge clock_i) begin
      if (reset_i || !enable_i) begin
         counter_q <= '0;
      end else if (edge_strobe) begin
         counter_q <= COUNTER_WIDTH'(1);
      end else if (counter_q != TIMEOUT_C) begin
         counter_q <= counter_q + COUNTER_WIDTH'(1);
      end
   end

   assign gap_hit     = (counter_q == SYNC_C);
   assign timeout_hit = (counter_q == TIMEOUT_C);
   assign interval_ok = (counter_q >= MIN_C) && (counter_q <= MAX_C);
   // An edge landing exactly on the sync threshold still counts as the end of a sync gap.
   assign start_frame = edge_strobe && ((state_q == GAP) || gap_hit);

   // Index never exceeds NUM_CHANNELS-1 while in CHAN, so an out-of-range select never matches.
   always_ff @(posedge clock_i) begin
      if (reset_i || !enable_i) begin
         state_q         <= WAIT_SYNC;
         index_q         <= '0;
         select_q        <= '0;
         channel_index_o <= '0;
         channel_width_o <= '0;
         channel_valid_o <= 1'b0;
         frame_done_o    <= 1'b0;
         frame_error_o   <= 1'b0;
         signal_lost_o   <= 1'b0;
         servo_pulse_o   <= 1'b0;
      end else begin
         channel_valid_o <= 1'b0;
         frame_done_o    <= 1'b0;
         frame_error_o   <= 1'b0;
         if (timeout_hit) begin
            signal_lost_o <= 1'b1;
            state_q       <= WAIT_SYNC;
            servo_pulse_o <= 1'b0;
         end else if (start_frame) begin
            frame_error_o <= (state_q == CHAN);
            state_q       <= CHAN;
            index_q       <= '0;
            select_q      <= channel_select_i;
            servo_pulse_o <= !signal_lost_o && (channel_select_i == '0);
         end else if (gap_hit && (state_q != GAP)) begin
            frame_error_o <= (state_q == CHAN);
            state_q       <= GAP;
            servo_pulse_o <= 1'b0;
         end else if ((state_q == CHAN) && edge_strobe) begin
            if (interval_ok) begin
               channel_valid_o <= 1'b1;
               channel_index_o <= index_q;
               channel_width_o <= counter_q;
               if (index_q == LAST_INDEX) begin
                  frame_done_o  <= 1'b1;
                  signal_lost_o <= 1'b0;
                  state_q       <= WAIT_SYNC;
                  servo_pulse_o <= 1'b0;
               end else begin
                  index_q       <= index_q + CHANNEL_INDEX_WIDTH'(1);
                  servo_pulse_o <= !signal_lost_o &&
                                   ((index_q + CHANNEL_INDEX_WIDTH'(1)) == select_q);
               end
            end else begin
               frame_error_o <= 1'b1;
               state_q       <= WAIT_SYNC;
               servo_pulse_o <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_ppm_frame_decoder.sv
// Scoreboard testbench for ppm_frame_decoder; timing constants are scaled by 1/10 to keep runs short.
// Define PPM_GLITCH_FILTER_EN for both bench and RTL to add the glitch-rejection frames.
module tb_ppm_frame_decoder;

   localparam int NUM_CH  = 8;
   localparam int MIN_P   = 80;
   localparam int MAX_P   = 220;
   localparam int SYNC_G  = 300;
   localparam int TIMEOUT = 5000;
   localparam int HIGH_T  = 30;
   localparam int GAP_T   = 400;

   logic        clock_i = 1'b0;
   logic        reset_i;
   logic        enable_i;
   logic        ppm_i;
   logic [2:0]  channel_select_i;
   logic [2:0]  channel_index_o;
   logic [15:0] channel_width_o;
   logic        channel_valid_o;
   logic        frame_done_o;
   logic        frame_error_o;
   logic        signal_lost_o;
   logic        servo_pulse_o;

   typedef struct {
      bit valid;
      bit done;
      bit error;
      int index;
      int width;
   } event_t;

   event_t event_q[$];
   int     pulse_q[$];
   event_t mon_event;
   int     servo_width;
   int     n_vectors = 0;
   int     n_miscompares = 0;
   bit     model_synced = 1'b0;
   bit     model_lost = 1'b0;
   int     slots[8];

   always #5 clock_i = ~clock_i;

   ppm_frame_decoder #(
      .NUM_CHANNELS    (NUM_CH),
      .COUNTER_WIDTH   (16),
      .MIN_PULSE_VALUE (MIN_P),
      .MAX_PULSE_VALUE (MAX_P),
      .SYNC_GAP_VALUE  (SYNC_G),
      .TIMEOUT_VALUE   (TIMEOUT)
   ) dut (
      .clock_i          (clock_i),
      .reset_i          (reset_i),
      .enable_i         (enable_i),
      .ppm_i            (ppm_i),
      .channel_select_i (channel_select_i),
      .channel_index_o  (channel_index_o),
      .channel_width_o  (channel_width_o),
      .channel_valid_o  (channel_valid_o),
      .frame_done_o     (frame_done_o),
      .frame_error_o    (frame_error_o),
      .signal_lost_o    (signal_lost_o),
      .servo_pulse_o    (servo_pulse_o)
   );

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      n_vectors++;
      if (actual !== expected) begin
         n_miscompares++;
         $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
      end
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(posedge clock_i);
      #1;
   endtask

   // One slot: rising edge, HIGH_T cycles high, then low until the next slot's edge.
   task automatic send_slot(input int len, input bit abort, input bit glitch);
      int half;
      ppm_i = 1'b1;
      wait_cycles(HIGH_T);
      ppm_i = 1'b0;
      if (abort) begin
         wait_cycles(5);
         enable_i = 1'b0;
         wait_cycles(3);
         checkOutput("disable_clears_width", channel_width_o, 0);
         enable_i = 1'b1;
         wait_cycles(len - HIGH_T - 8);
      end else if (glitch) begin
         half = (len - HIGH_T) / 2;
         wait_cycles(half);
         ppm_i = 1'b1;
         wait_cycles(1);
         ppm_i = 1'b0;
         wait_cycles(len - HIGH_T - half - 1);
      end else begin
         wait_cycles(len - HIGH_T);
      end
   endtask

   task automatic send_gap(input int len);
      send_slot(len, 1'b0, 1'b0);
      if (len >= SYNC_G) model_synced = 1'b1;
   endtask

   task automatic set_nominal();
      for (int i = 0; i < 8; i++) slots[i] = 100 + 10 * i;
   endtask

   // Pushes the expected strobes and servo pulse for slots[0..n-1], then drives the frame and its gap.
   task automatic applyStimulus(input int n, input int new_sel, input int abort_at, input bit glitch);
      int sel;
      bit ended;
      sel = int'(channel_select_i);
      if (model_synced) begin
         ended = 1'b0;
         for (int i = 0; i < n && !ended; i++) begin
            if (i == abort_at) begin
               ended = 1'b1;
            end else begin
               if (i == sel && !model_lost) pulse_q.push_back(slots[i]);
               if (slots[i] >= MIN_P && slots[i] <= MAX_P) begin
                  event_q.push_back('{1'b1, (i == NUM_CH - 1), 1'b0, i, slots[i]});
                  if (i == NUM_CH - 1) begin
                     model_lost = 1'b0;
                     ended = 1'b1;
                  end
               end else begin
                  event_q.push_back('{1'b0, 1'b0, 1'b1, 0, 0});
                  ended = 1'b1;
               end
            end
         end
         if (!ended) event_q.push_back('{1'b0, 1'b0, 1'b1, 0, 0});
      end
      model_synced = 1'b0;
      for (int i = 0; i < n; i++) begin
         if (i == 1 && new_sel >= 0) channel_select_i = 3'(new_sel);
         send_slot(slots[i], (i == abort_at), glitch);
      end
      send_gap(GAP_T);
   endtask

   initial begin
      forever begin
         @(negedge clock_i);
         if (channel_valid_o || frame_done_o || frame_error_o) begin
            if (event_q.size() == 0) begin
               checkOutput("unexpected_strobe", {channel_valid_o, frame_done_o, frame_error_o}, 0);
            end else begin
               mon_event = event_q.pop_front();
               checkOutput("channel_valid", channel_valid_o, mon_event.valid);
               checkOutput("frame_done", frame_done_o, mon_event.done);
               checkOutput("frame_error", frame_error_o, mon_event.error);
               if (mon_event.valid) begin
                  checkOutput("channel_index", channel_index_o, mon_event.index);
                  checkOutput("channel_width", channel_width_o, mon_event.width);
               end
            end
         end
      end
   end

   initial begin
      servo_width = 0;
      forever begin
         @(negedge clock_i);
         if (servo_pulse_o === 1'b1) begin
            servo_width++;
         end else if (servo_width > 0) begin
            if (pulse_q.size() == 0) checkOutput("unexpected_servo_pulse", servo_width, 0);
            else checkOutput("servo_width", servo_width, pulse_q.pop_front());
            servo_width = 0;
         end
      end
   end

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      reset_i = 1'b1;
      enable_i = 1'b1;
      ppm_i = 1'b0;
      channel_select_i = 3'd2;
      set_nominal();
      wait_cycles(3);

      // Frame running while reset is held, released mid-frame: nothing until the next sync gap.
      send_slot(GAP_T, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) send_slot(slots[i], 1'b0, 1'b0);
      checkOutput("reset_outputs", {channel_index_o, channel_width_o, channel_valid_o, frame_done_o,
                                    frame_error_o, signal_lost_o, servo_pulse_o}, 0);
      reset_i = 1'b0;
      for (int i = 3; i < 8; i++) send_slot(slots[i], 1'b0, 1'b0);
      send_gap(GAP_T);

      $display("[TB] nominal frames");
      applyStimulus(8, -1, -1, 1'b0);
      applyStimulus(8, -1, -1, 1'b0);

      $display("[TB] select change mid-frame");
      applyStimulus(8, 5, -1, 1'b0);
      applyStimulus(8, -1, -1, 1'b0);
      channel_select_i = 3'd2;

      $display("[TB] out-of-range slots");
      slots[3] = 70;
      applyStimulus(8, -1, -1, 1'b0);
      set_nominal();
      applyStimulus(8, -1, -1, 1'b0);
      slots[3] = 230;
      applyStimulus(8, -1, -1, 1'b0);
      set_nominal();
      applyStimulus(8, -1, -1, 1'b0);

      $display("[TB] boundary intervals");
      slots[0] = MIN_P;
      slots[7] = MAX_P;
      applyStimulus(8, -1, -1, 1'b0);
      set_nominal();
      slots[4] = MIN_P - 1;
      applyStimulus(8, -1, -1, 1'b0);
      set_nominal();
      slots[1] = MAX_P + 1;
      applyStimulus(8, -1, -1, 1'b0);
      set_nominal();
      applyStimulus(8, -1, -1, 1'b0);

      $display("[TB] short frame");
      applyStimulus(5, -1, -1, 1'b0);
      applyStimulus(8, -1, -1, 1'b0);

      $display("[TB] enable dropped mid-frame");
      applyStimulus(8, -1, 1, 1'b0);
      applyStimulus(8, -1, -1, 1'b0);

      $display("[TB] last channel selected");
      channel_select_i = 3'd7;
      applyStimulus(8, -1, -1, 1'b0);
      channel_select_i = 3'd2;

      $display("[TB] signal loss");
      wait_cycles(TIMEOUT + 100);
      checkOutput("signal_lost_set", signal_lost_o, 1);
      checkOutput("servo_while_lost", servo_pulse_o, 0);
      model_lost = 1'b1;
      model_synced = 1'b0;
      send_gap(GAP_T);
      applyStimulus(8, -1, -1, 1'b0);
      checkOutput("signal_lost_cleared", signal_lost_o, 0);
      applyStimulus(8, -1, -1, 1'b0);

`ifdef PPM_GLITCH_FILTER_EN
      $display("[TB] glitch spikes mid-slot");
      applyStimulus(8, -1, -1, 1'b1);
      applyStimulus(8, -1, -1, 1'b0);
`endif

      wait_cycles(20);
      checkOutput("events_drained", event_q.size(), 0);
      checkOutput("pulses_drained", pulse_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
      $finish;
   end

endmodule
